coef_axis_tx: RTL and testbench

- AXI-Stream master that transmits a block of 16-bit IIR coefficients to the filter's coefficient-load slave port.
- Packs two coefficients per 32-bit beat: even index in [31:16], odd index in [15:0]. Sends NUM_COEF/2 beats with tlast on the final beat.
- Coefficients are written by the control side into a live register bank. A start pulse snapshots that bank, so a transfer in flight is never corrupted.
- Sits between the PS/control register block and the filter's s_AXIS coefficient input.

---
 rtl/coef_axis_pkg.sv | 23 ++
 rtl/coef_axis_tx_bank.sv | 70 +++++++
 rtl/coef_axis_tx.sv | 119 +++++++++++
 tb/tb_coef_axis_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/coef_axis_pkg.sv
// Shared constants, FSM encoding and beat packing for the coefficient
// AXI-Stream transmitter.
package coef_axis_pkg;

    localparam int NUM_COEF_DEF = 12;
    localparam int COEF_W_DEF   = 16;
    localparam int BEATS        = NUM_COEF_DEF / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    // Even-index coefficient rides in the upper half of the beat.
    function automatic logic [2*COEF_W_DEF-1:0] pack_pair(
        input logic [COEF_W_DEF-1:0] hi,
        input logic [COEF_W_DEF-1:0] lo
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/coef_axis_tx_bank.sv
// Live coefficient bank written by the control side, plus a shadow bank
// snapshotted on start so an in-flight packet never sees later writes.
module coef_bank
    import coef_axis_pkg::*;
#(
    parameter int NUM_COEF = NUM_COEF_DEF,
    parameter int COEF_W   = COEF_W_DEF,
    parameter int BW       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [3:0]        addr,
    input  logic [COEF_W-1:0] wdata,
    input  logic              snap,
    input  logic              rd_live,
    input  logic [BW-1:0]     rd_beat,
    output logic [COEF_W-1:0] rd_hi,
    output logic [COEF_W-1:0] rd_lo
);

    localparam int N_BEATS = NUM_COEF / 2;

    logic [COEF_W-1:0] live     [NUM_COEF];
    logic [COEF_W-1:0] shadow   [NUM_COEF];
    logic [COEF_W-1:0] snap_val [NUM_COEF];

    // Same-cycle write is forwarded so a write coincident with start lands in the snapshot.
    always_comb begin
        for (int i = 0; i < NUM_COEF; i++) begin
            snap_val[i] = (we && (addr == 4'(i))) ? wdata : live[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_COEF; i++) begin
                if (we && (addr == 4'(i))) begin
                    live[i] <= wdata;
                end
                if (snap) begin
                    shadow[i] <= snap_val[i];
                end
            end
        end
    end

    // rd_live serves the first beat on the very edge that takes the snapshot.
    always_comb begin
        rd_hi = '0;
        rd_lo = '0;
        if (rd_live) begin
            rd_hi = snap_val[0];
            rd_lo = snap_val[1];
        end else begin
            for (int b = 0; b < N_BEATS; b++) begin
                if (rd_beat == BW'(b)) begin
                    rd_hi = shadow[2*b];
                    rd_lo = shadow[2*b+1];
                end
            end
        end
    end

endmodule

// File: rtl/coef_axis_tx.sv
// AXI-Stream master sending NUM_COEF/2 packed coefficient pairs per start,
// tlast on the final beat, done pulse one cycle after the last handshake.
module coef_axis_tx
    import coef_axis_pkg::*;
#(
    parameter int NUM_COEF = NUM_COEF_DEF,
    parameter int COEF_W   = COEF_W_DEF,
    parameter int DATA_W   = 2 * COEF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_we,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [3:0]        beat_cnt_moni,
    output logic [1:0]        state_dbg
);

    // Stream handshake: a beat transfers on a rising clk edge where
    // m_axis_tvalid && m_axis_tready; tvalid/tdata/tlast stay frozen until then
    // and tvalid is a pure register output, never a function of tready.

    localparam int         N_BEATS = NUM_COEF / 2;
    localparam int         BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(N_BEATS - 1);

    state_e            state;
    logic [BW-1:0]     beat;
    logic [BW-1:0]     rd_beat;
    logic [COEF_W-1:0] rd_hi;
    logic [COEF_W-1:0] rd_lo;
    logic              snap;
    logic              hs;

    assign snap    = (state == IDLE) && start;
    assign hs      = (state == SEND) && m_axis_tready;
    // Look one beat ahead so tdata is ready the edge the current beat is accepted.
    assign rd_beat = (beat == LAST) ? beat : beat + 1'b1;

    coef_bank #(
        .NUM_COEF (NUM_COEF),
        .COEF_W   (COEF_W),
        .BW       (BW)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (coef_we),
        .addr    (coef_addr),
        .wdata   (coef_wdata),
        .snap    (snap),
        .rd_live (snap),
        .rd_beat (rd_beat),
        .rd_hi   (rd_hi),
        .rd_lo   (rd_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= SEND;
                        beat          <= '0;
                        busy          <= 1'b1;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= DATA_W'(pack_pair(COEF_W_DEF'(rd_hi), COEF_W_DEF'(rd_lo)));
                        m_axis_tlast  <= (N_BEATS == 1);
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (beat == LAST) begin
                            state         <= DONE;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                        end else begin
                            beat          <= beat + 1'b1;
                            m_axis_tdata  <= DATA_W'(pack_pair(COEF_W_DEF'(rd_hi), COEF_W_DEF'(rd_lo)));
                            m_axis_tlast  <= (rd_beat == LAST);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    beat  <= '0;
                end
                default: begin
                    state         <= IDLE;
                    beat          <= '0;
                    busy          <= 1'b0;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            endcase
        end
    end

    assign beat_cnt_moni = 4'(beat);
    assign state_dbg     = state;

endmodule

// File: tb/tb_coef_axis_tx.sv
// Directed bench for coef_axis_tx: beats are predicted from a bench-side copy of
// the live bank at start time and checked in order as handshakes occur.
module tb_coef_axis_tx;

    localparam int NC = 12;
    localparam int NB = 6;
    localparam int EW = 37;  // {beat idx[3:0], tlast, tdata[31:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [15:0] coef_wdata = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic [3:0]  beat_cnt_moni;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    coef_axis_tx dut (
        .clk           (clk),
        .rst           (rst),
        .coef_we       (coef_we),
        .coef_addr     (coef_addr),
        .coef_wdata    (coef_wdata),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .beat_cnt_moni (beat_cnt_moni),
        .state_dbg     (state_dbg)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int beats_seen = 0;
    int last_hs_cyc = 0;
    logic [EW-1:0] exp_q[$];
    logic [15:0]   model[NC];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: in-order beat scoreboard plus stall stability.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_tvalid", 64'(m_axis_tvalid), 64'(1'b1));
                chk("stall_tdata", 64'(m_axis_tdata), 64'(prev_data));
                chk("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL unexpected_beat: observed %0h expected none", m_axis_tdata);
                end else begin
                    chk("beat", 64'({beat_cnt_moni, m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
                end
                beats_seen++;
                if (m_axis_tlast) last_hs_cyc = cyc;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic push_expected();
        for (int b = 0; b < NB; b++) begin
            exp_q.push_back({4'(b), (b == NB - 1), model[2*b], model[2*b+1]});
        end
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        tick();
        coef_we = 1'b0;
        if (int'(a) < NC) model[a] = d;
    endtask

    // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
    task automatic send_packet(input int ready_mode, input bit inject, input bit fwd,
                               input logic [3:0] fa, input logic [15:0] fd,
                               output int busy_cnt);
        int done_cyc;
        if (fwd) begin
            coef_we    = 1'b1;
            coef_addr  = fa;
            coef_wdata = fd;
            if (int'(fa) < NC) model[fa] = fd;
        end
        push_expected();
        beats_seen = 0;
        start = 1'b1;
        tick();
        start   = 1'b0;
        coef_we = 1'b0;
        busy_cnt = 0;
        done_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            case (ready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (i % 3 == 0);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            if (inject && i == 2) begin
                coef_we    = 1'b1;
                coef_addr  = 4'd0;
                coef_wdata = 16'hDEAD;
                start      = 1'b1;
                model[0]   = 16'hDEAD;
            end else begin
                coef_we = 1'b0;
                start   = 1'b0;
            end
            tick();
        end
        m_axis_tready = 1'b1;
        coef_we = 1'b0;
        start   = 1'b0;
        if (done_cyc < 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL done_timeout: observed no done expected done within 200 cycles");
        end else begin
            chk("done_latency", 64'(done_cyc), 64'(last_hs_cyc + 1));
            chk("beat_count", 64'(beats_seen), 64'(NB));
            chk("queue_empty", 64'(exp_q.size()), 64'(0));
        end
        tick();
        chk("done_width", 64'(done), 64'(1'b0));
        chk("busy_after", 64'(busy), 64'(1'b0));
    endtask

    initial begin
        int bc;
        for (int i = 0; i < NC; i++) model[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(1'b0));
        chk("rst_tlast", 64'(m_axis_tlast), 64'(1'b0));
        chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_beat", 64'(beat_cnt_moni), 64'(0));
        chk("rst_state", 64'(state_dbg), 64'(0));
        rst = 1'b0;
        tick();

        // Full-rate packet of 16'h1000+i
        for (int i = 0; i < NC; i++) write_coef(4'(i), 16'h1000 + 16'(i));
        send_packet(0, 1'b0, 1'b0, 4'd0, 16'd0, bc);
        chk("busy_cycles", 64'(bc), 64'(NB));

        // Stalling sink
        send_packet(1, 1'b0, 1'b0, 4'd0, 16'd0, bc);

        // Write and start during SEND; packet keeps snapshot, start not queued
        send_packet(0, 1'b1, 1'b0, 4'd0, 16'd0, bc);
        repeat (3) begin
            tick();
            chk("start_ignored", 64'(m_axis_tvalid), 64'(1'b0));
        end
        send_packet(0, 1'b0, 1'b0, 4'd0, 16'd0, bc);

        // Same-cycle write forwarded into snapshot
        send_packet(0, 1'b0, 1'b1, 4'd3, 16'h7FFF, bc);

        // Out-of-range writes ignored
        write_coef(4'd12, 16'h1234);
        write_coef(4'd15, 16'h5678);
        send_packet(2, 1'b0, 1'b0, 4'd0, 16'd0, bc);

        // Reset mid-packet
        push_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && beat_cnt_moni != 4'd3; i++) tick();
        chk("reached_beat3", 64'(beat_cnt_moni), 64'(3));
        rst = 1'b1;
        #1;
        chk("async_tvalid", 64'(m_axis_tvalid), 64'(1'b0));
        chk("async_tlast", 64'(m_axis_tlast), 64'(1'b0));
        exp_q.delete();
        for (int i = 0; i < NC; i++) model[i] = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 64'(busy), 64'(1'b0));
        chk("post_rst_beat", 64'(beat_cnt_moni), 64'(0));
        chk("post_rst_state", 64'(state_dbg), 64'(0));
        send_packet(0, 1'b0, 1'b0, 4'd0, 16'd0, bc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
